// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller: scans a double-buffered BCD value across common-anode digits,
// with a blank gap before each digit and optional leading-zero suppression.
module seven_segment_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable_i,
  input  logic                    lz_blank_i,
  input  logic                    load_valid_i,
  input  logic [4*NUM_DIGITS-1:0] load_data_i,
  output logic                    load_ready_o,
  output logic [3:0]              digit_code_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    frame_tick_o
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [IW-1:0] LAST      = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] SLOT_END  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;
  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] active_q, shadow_q;
  logic                    pending_q, ready_q, tick_q;
  logic [3:0]              code_q, eff, cur_digit;
  logic [NUM_DIGITS-1:0]   sel_q;
  logic                    frame_end, commit, accept, z, cur_zero;
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    if (!enable_i) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == IDLE) begin
      state_d = BLANK;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == BLANK && cnt_q == BLANK_END) begin
      state_d = SHOW;
    end else if (state_q == SHOW && cnt_q == SLOT_END) begin
      state_d = BLANK;
      cnt_d   = '0;
      idx_d   = idx_q == LAST ? '0 : idx_q + 1'b1;
    end
  end
  // z tracks "this digit and every digit above it are zero", scanning from the top down
  always_comb begin
    z         = 1'b1;
    cur_zero  = 1'b0;
    cur_digit = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z && active_q[4*i+:4] == 4'd0;
      if (idx_d == IW'(i)) begin
        cur_digit = active_q[4*i+:4];
        cur_zero  = z;
      end
    end
    eff = lz_blank_i && idx_d != '0 && cur_zero ? 4'hF : cur_digit;
  end
  assign frame_end = state_q == SHOW && idx_q == LAST && cnt_q == SLOT_END && enable_i;
  assign commit    = frame_end || (state_q == IDLE && pending_q);
  assign accept    = load_valid_i && ready_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      tick_q    <= 1'b0;
      code_q    <= 4'hF;
      sel_q     <= '1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      sel_q     <= state_d == SHOW ? ~(NUM_DIGITS'(1) << idx_d) : '1;
      code_q    <= state_d == SHOW ? eff : 4'hF;
      tick_q    <= state_d == SHOW && idx_d == LAST && cnt_d == SLOT_END;
      if (accept) shadow_q <= load_data_i;
      if (commit) active_q <= shadow_q;
      pending_q <= accept || (pending_q && !commit);
      ready_q   <= !(accept || (pending_q && !commit));
    end
  end
  assign load_ready_o = ready_q;
  assign digit_code_o = code_q;
  assign digit_sel_o  = sel_q;
  assign frame_tick_o = tick_q;
endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// tb_seven_segment_scan_controller: directed scenarios plus random traffic against a
// time-based reference model (scan position derived from cycles since scan start).
module tb_seven_segment_scan_controller;
  localparam int N = 4, RD = 8, BC = 2;
  logic clk = 1'b0;
  logic rst_n, enable, lz, lv, ready, tick;
  logic [15:0] ld;
  logic [3:0] code, sel;
  int checks = 0, errors = 0;
  bit sc, m_pending;
  int t;
  logic [15:0] m_active, m_shadow;
  logic [3:0] e_code, e_sel;
  bit e_tick, e_ready;
  logic [3:0] seen [N];
  int ticks;

  seven_segment_scan_controller #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .lz_blank_i(lz), .load_valid_i(lv),
    .load_data_i(ld), .load_ready_o(ready), .digit_code_o(code), .digit_sel_o(sel),
    .frame_tick_o(tick)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] eff_digit(logic [15:0] v, int d, bit lzb);
    int hi = -1;
    for (int i = 0; i < N; i++) if (v[4*i+:4] != 0) hi = i;
    return (lzb && d > 0 && d > hi) ? 4'hF : v[4*d+:4];
  endfunction

  task automatic model_edge();
    bit sc0 = sc, p0 = m_pending, fe, cm, acc;
    int t0 = t, d;
    logic [15:0] a0 = m_active, s0 = m_shadow;
    if (!rst_n) begin
      sc = 0; t = 0; m_active = 0; m_shadow = 0; m_pending = 0;
    end else begin
      fe  = sc0 && enable && t0 == N*RD - 1;
      cm  = fe || (!sc0 && p0);
      acc = lv && !p0;
      if (!enable) begin sc = 0; t = 0; end
      else if (!sc0) begin sc = 1; t = 0; end
      else t = (t0 + 1) % (N*RD);
      m_pending = acc ? 1'b1 : cm ? 1'b0 : p0;
      if (cm) m_active = s0;
      if (acc) m_shadow = ld;
    end
    e_sel = 4'hF; e_code = 4'hF; e_tick = 0;
    if (sc && t % RD >= BC) begin
      d = (t / RD) % N;
      e_sel = ~(4'b0001 << d);
      e_code = eff_digit(a0, d, lz);
    end
    e_tick = sc && t == N*RD - 1;
    e_ready = !m_pending;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("sel", sel, e_sel);
    check("code", code, e_code);
    check("tick", tick, e_tick);
    check("ready", ready, e_ready);
  endtask

  task automatic scan_frame();
    for (int d = 0; d < N; d++) seen[d] = 4'hE;
    ticks = 0;
    for (int k = 0; k < N*RD; k++) begin
      step();
      for (int d = 0; d < N; d++) if (sel[d] == 1'b0) seen[d] = code;
      if (tick) ticks++;
    end
  endtask

  task automatic load_idle(logic [15:0] v);
    enable = 0; lv = 1; ld = v;
    step();
    lv = 0; ld = $urandom;
    step();
  endtask

  initial begin
    rst_n = 0; enable = 0; lz = 0; lv = 0; ld = 0;
    step(); step();
    check("rst_sel", sel, 4'hF);
    check("rst_code", code, 4'hF);
    check("rst_ready", ready, 1);
    check("rst_tick", tick, 0);
    rst_n = 1;
    lv = 1; ld = 16'h1234;
    step();
    check("t1_busy", ready, 0);
    lv = 0;
    step();
    check("t1_free", ready, 1);
    check("t1_dark", sel, 4'hF);
    enable = 1;
    scan_frame();
    check("t2_d0", seen[0], 4'h4);
    check("t2_d1", seen[1], 4'h3);
    check("t2_d2", seen[2], 4'h2);
    check("t2_d3", seen[3], 4'h1);
    check("t2_ticks", ticks, 1);
    lz = 1;
    load_idle(16'h0042);
    enable = 1;
    scan_frame();
    check("t3_d0", seen[0], 4'h2);
    check("t3_d1", seen[1], 4'h4);
    check("t3_d2", seen[2], 4'hF);
    check("t3_d3", seen[3], 4'hF);
    load_idle(16'h0000);
    enable = 1;
    scan_frame();
    check("t3z_d0", seen[0], 4'h0);
    check("t3z_d1", seen[1], 4'hF);
    check("t3z_d3", seen[3], 4'hF);
    lv = 1; ld = 16'h5678;
    step();
    lv = 0;
    for (int k = 0; k < 16 && sel == 4'hF; k++) step();
    check("t6_showing", sel != 4'hF, 1);
    rst_n = 0;
    step();
    check("t6_sel", sel, 4'hF);
    check("t6_code", code, 4'hF);
    check("t6_ready", ready, 1);
    rst_n = 1;
    enable = 1; lz = 0;
    scan_frame();
    check("t6_active0", seen[2], 4'h0);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      if ($urandom_range(0, 19) == 0) lz = ~lz;
      rst_n = $urandom_range(0, 499) != 0;
      lv = $urandom_range(0, 7) == 0;
      for (int d = 0; d < N; d++) ld[4*d+:4] = $urandom_range(0, 1) ? 4'(0) : 4'($urandom_range(0, 15));
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
